// File: rtl/tlb_core.sv
// tlb_core: joint MIPS32 TLB array with TLBNUM entries. Each entry maps an
// even/odd 4 KB page pair.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   s0_* / s1_*         two independent combinational lookup ports
//                       (port 0: instruction MMU, port 1: data MMU / TLBP).
//                       Inputs: vpn (VPN2), odd (page select), asid.
//                       Outputs: found, index, pfn, c, d, v.
//   we, w_*             entry write (TLBWI/TLBWR), takes effect at clk edge
//   r_index, r_*        combinational entry read (TLBR)
//
// Searches and reads see the registered contents only, so a write becomes
// visible the cycle after it is presented. Multiple hits resolve to the
// lowest matching index.
module tlb_core #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  // search port 0
  input  logic [18:0]   s0_vpn,
  input  logic          s0_odd,
  input  logic [7:0]    s0_asid,
  output logic          s0_found,
  output logic [IW-1:0] s0_index,
  output logic [19:0]   s0_pfn,
  output logic [2:0]    s0_c,
  output logic          s0_d,
  output logic          s0_v,
  // search port 1
  input  logic [18:0]   s1_vpn,
  input  logic          s1_odd,
  input  logic [7:0]    s1_asid,
  output logic          s1_found,
  output logic [IW-1:0] s1_index,
  output logic [19:0]   s1_pfn,
  output logic [2:0]    s1_c,
  output logic          s1_d,
  output logic          s1_v,
  // write port
  input  logic          we,
  input  logic [IW-1:0] w_index,
  input  logic [18:0]   w_vpn2,
  input  logic [7:0]    w_asid,
  input  logic          w_g,
  input  logic [19:0]   w_pfn0,
  input  logic [2:0]    w_c0,
  input  logic          w_d0,
  input  logic          w_v0,
  input  logic [19:0]   w_pfn1,
  input  logic [2:0]    w_c1,
  input  logic          w_d1,
  input  logic          w_v1,
  // read port
  input  logic [IW-1:0] r_index,
  output logic [18:0]   r_vpn2,
  output logic [7:0]    r_asid,
  output logic          r_g,
  output logic [19:0]   r_pfn0,
  output logic [2:0]    r_c0,
  output logic          r_d0,
  output logic          r_v0,
  output logic [19:0]   r_pfn1,
  output logic [2:0]    r_c1,
  output logic          r_d1,
  output logic          r_v1
);

  // Entry storage
  logic [18:0]       vpn2_q [TLBNUM];
  logic [7:0]        asid_q [TLBNUM];
  logic [TLBNUM-1:0] g_q;
  logic [19:0]       pfn0_q [TLBNUM];
  logic [2:0]        c0_q   [TLBNUM];
  logic [TLBNUM-1:0] d0_q;
  logic [TLBNUM-1:0] v0_q;
  logic [19:0]       pfn1_q [TLBNUM];
  logic [2:0]        c1_q   [TLBNUM];
  logic [TLBNUM-1:0] d1_q;
  logic [TLBNUM-1:0] v1_q;
  // An all-zero entry must not match vpn 0 / asid 0 after reset, so each
  // entry carries its own "has been written" flag.
  logic [TLBNUM-1:0] written_q;

  // Search inputs gathered so both ports share one generate body
  logic [18:0] s_vpn  [2];
  logic        s_odd  [2];
  logic [7:0]  s_asid [2];

  assign s_vpn[0]  = s0_vpn;
  assign s_odd[0]  = s0_odd;
  assign s_asid[0] = s0_asid;
  assign s_vpn[1]  = s1_vpn;
  assign s_odd[1]  = s1_odd;
  assign s_asid[1] = s1_asid;

  genvar gi;
  genvar gp;

  // Per-entry write logic; rst has priority so a write with rst is dropped.
  generate
    for (gi = 0; gi < TLBNUM; gi++) begin : entry_g
      always_ff @(posedge clk) begin
        if (rst) begin
          vpn2_q[gi]    <= '0;
          asid_q[gi]    <= '0;
          g_q[gi]       <= 1'b0;
          pfn0_q[gi]    <= '0;
          c0_q[gi]      <= '0;
          d0_q[gi]      <= 1'b0;
          v0_q[gi]      <= 1'b0;
          pfn1_q[gi]    <= '0;
          c1_q[gi]      <= '0;
          d1_q[gi]      <= 1'b0;
          v1_q[gi]      <= 1'b0;
          written_q[gi] <= 1'b0;
        end else if (we && (w_index == IW'(gi))) begin
          vpn2_q[gi]    <= w_vpn2;
          asid_q[gi]    <= w_asid;
          g_q[gi]       <= w_g;
          pfn0_q[gi]    <= w_pfn0;
          c0_q[gi]      <= w_c0;
          d0_q[gi]      <= w_d0;
          v0_q[gi]      <= w_v0;
          pfn1_q[gi]    <= w_pfn1;
          c1_q[gi]      <= w_c1;
          d1_q[gi]      <= w_d1;
          v1_q[gi]      <= w_v1;
          written_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Lookup ports
  generate
    for (gp = 0; gp < 2; gp++) begin : port_g
      logic [TLBNUM-1:0] match;
      logic              found;
      logic [IW-1:0]     idx;
      logic [19:0]       pfn;
      logic [2:0]        c;
      logic              d;
      logic              v;

      for (gi = 0; gi < TLBNUM; gi++) begin : cmp_g
        assign match[gi] = written_q[gi]
                         && (vpn2_q[gi] == s_vpn[gp])
                         && (g_q[gi] || (asid_q[gi] == s_asid[gp]));
      end

      // Scan from the top down so the lowest matching index is kept last.
      always_comb begin
        idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
          if (match[i]) begin
            idx = IW'(i);
          end
        end
      end

      assign found = |match;

      always_comb begin
        pfn = '0;
        c   = '0;
        d   = 1'b0;
        v   = 1'b0;
        if (found) begin
          if (s_odd[gp]) begin
            pfn = pfn1_q[idx];
            c   = c1_q[idx];
            d   = d1_q[idx];
            v   = v1_q[idx];
          end else begin
            pfn = pfn0_q[idx];
            c   = c0_q[idx];
            d   = d0_q[idx];
            v   = v0_q[idx];
          end
        end
      end
    end
  endgenerate

  assign s0_found = port_g[0].found;
  assign s0_index = port_g[0].idx;
  assign s0_pfn   = port_g[0].pfn;
  assign s0_c     = port_g[0].c;
  assign s0_d     = port_g[0].d;
  assign s0_v     = port_g[0].v;

  assign s1_found = port_g[1].found;
  assign s1_index = port_g[1].idx;
  assign s1_pfn   = port_g[1].pfn;
  assign s1_c     = port_g[1].c;
  assign s1_d     = port_g[1].d;
  assign s1_v     = port_g[1].v;

  // Read port: unwritten entries hold the reset value of zero.
  assign r_vpn2 = vpn2_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign r_pfn0 = pfn0_q[r_index];
  assign r_c0   = c0_q[r_index];
  assign r_d0   = d0_q[r_index];
  assign r_v0   = v0_q[r_index];
  assign r_pfn1 = pfn1_q[r_index];
  assign r_c1   = c1_q[r_index];
  assign r_d1   = d1_q[r_index];
  assign r_v1   = v1_q[r_index];

endmodule

// File: tb/tb_tlb_core.sv
// tb_tlb_core: self-checking bench for tlb_core (TLBNUM=16). Directed steps
// followed by random write/search/read traffic, all compared against a
// field-array reference model of the TLB.
module tb_tlb_core;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [18:0]   s0_vpn,  s1_vpn;
  logic          s0_odd,  s1_odd;
  logic [7:0]    s0_asid, s1_asid;
  logic          s0_found, s1_found;
  logic [IW-1:0] s0_index, s1_index;
  logic [19:0]   s0_pfn,  s1_pfn;
  logic [2:0]    s0_c,    s1_c;
  logic          s0_d,    s1_d;
  logic          s0_v,    s1_v;
  logic          we;
  logic [IW-1:0] w_index;
  logic [18:0]   w_vpn2;
  logic [7:0]    w_asid;
  logic          w_g;
  logic [19:0]   w_pfn0, w_pfn1;
  logic [2:0]    w_c0,   w_c1;
  logic          w_d0, w_v0, w_d1, w_v1;
  logic [IW-1:0] r_index;
  logic [18:0]   r_vpn2;
  logic [7:0]    r_asid;
  logic          r_g;
  logic [19:0]   r_pfn0, r_pfn1;
  logic [2:0]    r_c0,   r_c1;
  logic          r_d0, r_v0, r_d1, r_v1;

  int total = 0;
  int bad   = 0;

  // Reference model: one record per entry
  logic [18:0] m_vpn2 [N];
  logic [7:0]  m_asid [N];
  logic        m_g    [N];
  logic [19:0] m_pfn0 [N];
  logic [2:0]  m_c0   [N];
  logic        m_d0   [N];
  logic        m_v0   [N];
  logic [19:0] m_pfn1 [N];
  logic [2:0]  m_c1   [N];
  logic        m_d1   [N];
  logic        m_v1   [N];
  logic        m_written [N];

  tlb_core #(.TLBNUM(N)) dut (
    .clk(clk), .rst(rst),
    .s0_vpn(s0_vpn), .s0_odd(s0_odd), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn(s1_vpn), .s1_odd(s1_odd), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {found, index, pfn, c, d, v} for a lookup
  function automatic logic [29:0] exp_lookup(input logic [18:0] vpn, input logic odd,
                                             input logic [7:0] asid);
    for (int i = 0; i < N; i++) begin
      if (m_written[i] && m_vpn2[i] == vpn && (m_g[i] || m_asid[i] == asid)) begin
        if (odd) return {1'b1, 4'(i), m_pfn1[i], m_c1[i], m_d1[i], m_v1[i]};
        else     return {1'b1, 4'(i), m_pfn0[i], m_c0[i], m_d0[i], m_v0[i]};
      end
    end
    return '0;
  endfunction

  function automatic logic [77:0] exp_read(input int i);
    return {m_vpn2[i], m_asid[i], m_g[i], m_pfn0[i], m_c0[i], m_d0[i], m_v0[i],
            m_pfn1[i], m_c1[i], m_d1[i], m_v1[i]};
  endfunction

  task automatic check_all(input string tag);
    #1;
    check({tag, "/s0"}, {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
          exp_lookup(s0_vpn, s0_odd, s0_asid));
    check({tag, "/s1"}, {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v},
          exp_lookup(s1_vpn, s1_odd, s1_asid));
    check({tag, "/rd"}, {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                         r_pfn1, r_c1, r_d1, r_v1}, exp_read(int'(r_index)));
    $display("step %s: s0 %0h/%0b/%0h -> f=%0b i=%0d | s1 %0h/%0b/%0h -> f=%0b i=%0d | r%0d",
             tag, s0_vpn, s0_odd, s0_asid, s0_found, s0_index,
             s1_vpn, s1_odd, s1_asid, s1_found, s1_index, r_index);
  endtask

  // Clock edge, then update the model with what the edge should have done.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
        m_pfn0[i] = '0; m_c0[i] = '0; m_d0[i] = 1'b0; m_v0[i] = 1'b0;
        m_pfn1[i] = '0; m_c1[i] = '0; m_d1[i] = 1'b0; m_v1[i] = 1'b0;
        m_written[i] = 1'b0;
      end
    end else if (we) begin
      m_vpn2[w_index] = w_vpn2; m_asid[w_index] = w_asid; m_g[w_index] = w_g;
      m_pfn0[w_index] = w_pfn0; m_c0[w_index] = w_c0;
      m_d0[w_index] = w_d0; m_v0[w_index] = w_v0;
      m_pfn1[w_index] = w_pfn1; m_c1[w_index] = w_c1;
      m_d1[w_index] = w_d1; m_v1[w_index] = w_v1;
      m_written[w_index] = 1'b1;
    end
    #1;
  endtask

  task automatic set_write(input logic [3:0] idx, input logic [18:0] vpn, input logic [7:0] asid,
                           input logic g, input logic [19:0] p0, input logic [2:0] c0,
                           input logic d0, input logic v0, input logic [19:0] p1,
                           input logic [2:0] c1, input logic d1, input logic v1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn; w_asid = asid; w_g = g;
    w_pfn0 = p0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = p1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  function automatic logic [18:0] pick_vpn();
    case ($urandom_range(0, 3))
      0: return 19'h12345;
      1: return 19'h00000;
      2: return 19'h2AAAA;
      default: return 19'h7FFFF;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < N; i++) m_written[i] = 1'b0;
    rst = 1'b1; we = 1'b0;
    set_write(4'd0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    we = 1'b0;
    s0_vpn = '0; s0_odd = 1'b0; s0_asid = '0;
    s1_vpn = '0; s1_odd = 1'b1; s1_asid = '0;
    r_index = '0;
    tick();
    rst = 1'b0;

    // After reset: vpn 0 / asid 0 misses on both ports, reads are zero
    check_all("reset");
    check("reset_s0_found", s0_found, 1'b0);
    r_index = 4'd5;
    check_all("reset_r5");

    // Write entry 5; same-cycle search still sees the old (empty) entry
    set_write(4'd5, 19'h12345, 8'h0A, 1'b0, 20'h00ABC, 3'd3, 1'b0, 1'b1,
              20'h00DEF, 3'd2, 1'b1, 1'b0);
    s0_vpn = 19'h12345; s0_odd = 1'b0; s0_asid = 8'h0A;
    check_all("wr5_same_cycle");
    check("wr5_nobypass_found", s0_found, 1'b0);
    tick();
    we = 1'b0;
    check_all("wr5_even");
    check("wr5_index", s0_index, 4'd5);
    check("wr5_pfn", s0_pfn, 20'h00ABC);
    check("wr5_c_v", {s0_c, s0_v}, {3'd3, 1'b1});
    s0_odd = 1'b1;
    check_all("wr5_odd");
    check("wr5_odd_pfn_v", {s0_found, s0_pfn, s0_v}, {1'b1, 20'h00DEF, 1'b0});

    // ASID mismatch, then global rewrite
    s0_asid = 8'h0B;
    check_all("asid_miss");
    check("asid_miss_found", s0_found, 1'b0);
    set_write(4'd5, 19'h12345, 8'h0A, 1'b1, 20'h00ABC, 3'd3, 1'b0, 1'b1,
              20'h00DEF, 3'd2, 1'b1, 1'b0);
    tick();
    we = 1'b0;
    check_all("global_hit");
    check("global_found", s0_found, 1'b1);

    // Duplicate entries at 9 and 3: lowest index wins on both ports
    set_write(4'd9, 19'h2AAAA, 8'h11, 1'b0, 20'h99999, 3'd1, 1'b1, 1'b1,
              20'h99990, 3'd1, 1'b1, 1'b1);
    tick();
    set_write(4'd3, 19'h2AAAA, 8'h11, 1'b0, 20'h33333, 3'd4, 1'b0, 1'b1,
              20'h33330, 3'd4, 1'b0, 1'b1);
    tick();
    we = 1'b0;
    s0_vpn = 19'h2AAAA; s0_odd = 1'b0; s0_asid = 8'h11;
    s1_vpn = 19'h2AAAA; s1_odd = 1'b0; s1_asid = 8'h11;
    r_index = 4'd9;
    check_all("dup_both");
    check("dup_s0_idx_pfn", {s0_index, s0_pfn}, {4'd3, 20'h33333});
    check("dup_s1_idx_pfn", {s1_index, s1_pfn}, {4'd3, 20'h33333});
    s1_vpn = 19'h55555;
    check_all("dup_s1_miss");
    check("dup_s1_found", s1_found, 1'b0);

    // Reset wins over a simultaneous write
    rst = 1'b1;
    set_write(4'd2, 19'h00001, 8'h01, 1'b1, 20'h11111, 3'd7, 1'b1, 1'b1,
              20'h22222, 3'd7, 1'b1, 1'b1);
    tick();
    rst = 1'b0; we = 1'b0;
    s0_vpn = 19'h00001; s0_asid = 8'h01;
    s1_vpn = 19'h2AAAA; s1_asid = 8'h11;
    for (int i = 0; i < N; i++) begin
      r_index = 4'(i);
      check_all($sformatf("rstwe_r%0d", i));
    end
    check("rstwe_s0_found", s0_found, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_write(4'($urandom_range(0, N - 1)), pick_vpn(), 8'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0), 20'($urandom), 3'($urandom),
                1'($urandom), 1'($urandom), 20'($urandom), 3'($urandom),
                1'($urandom), 1'($urandom));
      we = 1'($urandom_range(0, 1));
      s0_vpn = pick_vpn(); s0_odd = 1'($urandom); s0_asid = 8'($urandom_range(0, 3));
      s1_vpn = pick_vpn(); s1_odd = 1'($urandom); s1_asid = 8'($urandom_range(0, 3));
      r_index = 4'($urandom_range(0, N - 1));
      check_all($sformatf("rnd%0d", n));
      tick();
    end
    rst = 1'b0; we = 1'b0;
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
